display_timing_ctrl: RTL and testbench

//  Display-controller side of the display setup handshake. Generates raster

---
 rtl/display_timing_ctrl.sv | 142 ++++++++++++++
 tb/tb_display_timing_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/display_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : display_timing_ctrl
// Brief    : Raster timing (HSYNC/VSYNC/DE), frame-buffer address generation
//            and sticky VBLANK flag for the display setup handshake.
// Revision : 1.0 - initial release
// ============================================================================
module display_timing_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] DISPADDR,
    input  logic        DISPON,
    input  logic        CLRVBLNK,
    output logic        VBLANK,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic        DE,
    output logic [29:0] FB_ADDR
);

    localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = (c_h_total > 1) ? $clog2(c_h_total) : 1;
    localparam int VW = (c_v_total > 1) ? $clog2(c_v_total) : 1;

    localparam logic [HW-1:0] c_h_act_end   = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] c_h_front_end = HW'(H_ACTIVE + H_FP - 1);
    localparam logic [HW-1:0] c_h_sync_end  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [HW-1:0] c_h_last      = HW'(c_h_total - 1);
    localparam logic [VW-1:0] c_v_act_end   = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] c_v_front_end = VW'(V_ACTIVE + V_FP - 1);
    localparam logic [VW-1:0] c_v_sync_end  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [VW-1:0] c_v_last      = VW'(c_v_total - 1);
    localparam logic [VW-1:0] c_v_blank_row = VW'(V_ACTIVE);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_FRONT  = 2'd1,
        ST_SYNC   = 2'd2,
        ST_BACK   = 2'd3
    } region_t;

    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    region_t       r_h_state, w_h_state_nxt;
    region_t       r_v_state, w_v_state_nxt;
    logic          r_en;
    logic [29:0]   r_addr_cnt;

    logic          w_h_last, w_v_last;
    logic          w_frame_start, w_en, w_de, w_hsync, w_vsync, w_vblank_set;
    logic [29:0]   w_pix_addr;

    assign w_h_last = (r_hcnt == c_h_last);
    assign w_v_last = (r_vcnt == c_v_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hcnt    <= '0;
            r_vcnt    <= '0;
            r_h_state <= ST_ACTIVE;
            r_v_state <= ST_ACTIVE;
        end else begin
            r_hcnt    <= w_h_last ? '0 : r_hcnt + 1'b1;
            if (w_h_last) begin
                r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
            end
            r_h_state <= w_h_state_nxt;
            r_v_state <= w_v_state_nxt;
        end
    end

    // Region state always describes the counter value currently held.
    always_comb begin
        w_h_state_nxt = r_h_state;
        w_v_state_nxt = r_v_state;
        case (r_h_state)
            ST_ACTIVE: if (r_hcnt == c_h_act_end)   w_h_state_nxt = ST_FRONT;
            ST_FRONT:  if (r_hcnt == c_h_front_end) w_h_state_nxt = ST_SYNC;
            ST_SYNC:   if (r_hcnt == c_h_sync_end)  w_h_state_nxt = ST_BACK;
            ST_BACK:   if (r_hcnt == c_h_last)      w_h_state_nxt = ST_ACTIVE;
        endcase
        if (w_h_last) begin
            case (r_v_state)
                ST_ACTIVE: if (r_vcnt == c_v_act_end)   w_v_state_nxt = ST_FRONT;
                ST_FRONT:  if (r_vcnt == c_v_front_end) w_v_state_nxt = ST_SYNC;
                ST_SYNC:   if (r_vcnt == c_v_sync_end)  w_v_state_nxt = ST_BACK;
                ST_BACK:   if (r_vcnt == c_v_last)      w_v_state_nxt = ST_ACTIVE;
            endcase
        end
        w_hsync       = (r_h_state != ST_SYNC);
        w_vsync       = (r_v_state != ST_SYNC);
        w_frame_start = (r_hcnt == '0) && (r_vcnt == '0);
        w_en          = w_frame_start ? DISPON : r_en;
        w_de          = (r_h_state == ST_ACTIVE) && (r_v_state == ST_ACTIVE) && w_en;
        w_pix_addr    = w_frame_start ? DISPADDR : r_addr_cnt;
        w_vblank_set  = (r_hcnt == '0) && (r_vcnt == c_v_blank_row);
    end

    // The address counter doubles as the latched base: it is loaded at frame
    // start and steps once per visible pixel, so it tracks base+v*H_ACTIVE+h.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en       <= 1'b0;
            r_addr_cnt <= '0;
            HSYNC      <= 1'b1;
            VSYNC      <= 1'b1;
            DE         <= 1'b0;
            FB_ADDR    <= '0;
            VBLANK     <= 1'b0;
        end else begin
            HSYNC <= w_hsync;
            VSYNC <= w_vsync;
            DE    <= w_de;
            if (w_frame_start) begin
                r_en <= DISPON;
            end
            if (w_de) begin
                FB_ADDR    <= w_pix_addr;
                r_addr_cnt <= w_pix_addr + 30'd1;
            end else if (w_frame_start) begin
                r_addr_cnt <= DISPADDR;
            end
            if (CLRVBLNK) begin
                VBLANK <= 1'b0;
            end else if (w_vblank_set) begin
                VBLANK <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_display_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_timing_ctrl
// Brief    : Scoreboard bench for display_timing_ctrl on an 8x6 raster.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_timing_ctrl;

    logic        clk;
    logic        rst;
    logic [29:0] DISPADDR;
    logic        DISPON;
    logic        CLRVBLNK;
    logic        VBLANK;
    logic        HSYNC;
    logic        VSYNC;
    logic        DE;
    logic [29:0] FB_ADDR;

    display_timing_ctrl #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .DISPADDR (DISPADDR),
        .DISPON   (DISPON),
        .CLRVBLNK (CLRVBLNK),
        .VBLANK   (VBLANK),
        .HSYNC    (HSYNC),
        .VSYNC    (VSYNC),
        .DE       (DE),
        .FB_ADDR  (FB_ADDR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic        vb;
        logic [29:0] fb;
    } exp_t;

    exp_t        r_sb[$];
    int          r_total = 0;
    int          r_bad   = 0;
    int          r_edge  = 0;
    int          r_de_cnt, r_hs_lo, r_vs_lo, r_vb_hits;
    int          m_h, m_v;
    logic        m_en, m_vb;
    logic [29:0] m_base, m_fb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_total++;
        if (got !== exp) begin
            r_bad++;
            $display("FAIL %s edge=%0d got=0x%0h exp=0x%0h", tag, r_edge, got, exp);
        end
    endtask

    task automatic model_reset();
        m_h = 0; m_v = 0; m_en = 1'b0; m_vb = 1'b0; m_base = '0; m_fb = '0;
        r_sb.delete();
        r_edge = 0;
    endtask

    // Predict the edge from the pre-edge raster position, then compare after it.
    task automatic tick();
        exp_t e;
        exp_t g;
        if (m_h == 0 && m_v == 0) begin
            m_en   = DISPON;
            m_base = DISPADDR;
        end
        e.de = (m_h < 4) && (m_v < 3) && m_en;
        e.hs = !(m_h >= 5 && m_h < 7);
        e.vs = (m_v != 4);
        if (e.de) m_fb = m_base + 30'(m_v * 4 + m_h);
        e.fb = m_fb;
        if (CLRVBLNK) m_vb = 1'b0;
        else if (m_h == 0 && m_v == 3) m_vb = 1'b1;
        e.vb = m_vb;
        r_sb.push_back(e);
        @(posedge clk);
        #1;
        r_edge++;
        g = r_sb.pop_front();
        chk("de", {31'd0, DE}, {31'd0, g.de});
        chk("hsync", {31'd0, HSYNC}, {31'd0, g.hs});
        chk("vsync", {31'd0, VSYNC}, {31'd0, g.vs});
        chk("vblank", {31'd0, VBLANK}, {31'd0, g.vb});
        chk("fb_addr", {2'd0, FB_ADDR}, {2'd0, g.fb});
        if (DE) r_de_cnt++;
        if (!HSYNC) r_hs_lo++;
        if (!VSYNC) r_vs_lo++;
        if (VBLANK) r_vb_hits++;
        m_h++;
        if (m_h == 8) begin
            m_h = 0;
            m_v = (m_v == 5) ? 0 : m_v + 1;
        end
    endtask

    task automatic run_to(input int n);
        while (r_edge < n) tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_de"}, {31'd0, DE}, 32'd0);
        chk({tag, "_hsync"}, {31'd0, HSYNC}, 32'd1);
        chk({tag, "_vsync"}, {31'd0, VSYNC}, 32'd1);
        chk({tag, "_vblank"}, {31'd0, VBLANK}, 32'd0);
        chk({tag, "_fb"}, {2'd0, FB_ADDR}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; DISPADDR = 30'h13800000; DISPON = 1'b1; CLRVBLNK = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst_init");
        rst = 1'b0;

        // Frame 1: video, syncs and first VBLANK rise
        r_de_cnt = 0; r_hs_lo = 0; r_vs_lo = 0;
        run_to(2);
        CLRVBLNK = 1'b0;
        run_to(24);
        chk("vb_before_rise", {31'd0, VBLANK}, 32'd0);
        run_to(25);
        chk("vb_rise_25", {31'd0, VBLANK}, 32'd1);
        run_to(48);
        chk("f1_de_cycles", r_de_cnt, 32'd12);
        chk("f1_hsync_low", r_hs_lo, 32'd12);
        chk("f1_vsync_low", r_vs_lo, 32'd8);
        chk("f1_last_addr", {2'd0, FB_ADDR}, 32'h1380000B);

        // Sticky flag, one-cycle clear, re-rise one frame later
        run_to(60);
        chk("vb_sticky", {31'd0, VBLANK}, 32'd1);
        CLRVBLNK = 1'b1; tick(); CLRVBLNK = 1'b0;
        chk("vb_cleared", {31'd0, VBLANK}, 32'd0);
        run_to(72);
        chk("vb_pre_rerise", {31'd0, VBLANK}, 32'd0);
        run_to(73);
        chk("vb_rerise_73", {31'd0, VBLANK}, 32'd1);

        // Clear coinciding with the set event drops that frame's event
        run_to(100);
        CLRVBLNK = 1'b1; tick(); CLRVBLNK = 1'b0;
        run_to(120);
        CLRVBLNK = 1'b1; r_vb_hits = 0; tick(); CLRVBLNK = 1'b0;
        run_to(144);
        chk("vb_dropped_frame", r_vb_hits, 32'd0);

        // Mid-frame DISPADDR/DISPON changes apply from the next frame
        r_de_cnt = 0;
        run_to(150);
        DISPADDR = 30'h00000100;
        run_to(154);
        DISPON = 1'b0;
        run_to(192);
        chk("f4_de_unaffected", r_de_cnt, 32'd12);
        r_de_cnt = 0; r_hs_lo = 0; r_vs_lo = 0;
        CLRVBLNK = 1'b1; tick(); CLRVBLNK = 1'b0;
        run_to(216);
        chk("f5_vb_pre", {31'd0, VBLANK}, 32'd0);
        run_to(217);
        chk("f5_vb_rise", {31'd0, VBLANK}, 32'd1);
        run_to(230);
        DISPON = 1'b1;
        run_to(240);
        chk("f5_de_off", r_de_cnt, 32'd0);
        chk("f5_hsync_low", r_hs_lo, 32'd12);
        chk("f5_vsync_low", r_vs_lo, 32'd8);
        chk("f5_fb_frozen", {2'd0, FB_ADDR}, 32'h1380000B);
        run_to(241);
        chk("f6_first_de", {31'd0, DE}, 32'd1);
        chk("f6_first_addr", {2'd0, FB_ADDR}, 32'h00000100);

        // Asynchronous reset mid-line while DE is high
        run_to(251);
        chk("pre_rst_de", {31'd0, DE}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        r_de_cnt = 0;
        tick();
        chk("restart_de", {31'd0, DE}, 32'd1);
        chk("restart_addr", {2'd0, FB_ADDR}, 32'h00000100);
        run_to(48);
        chk("restart_de_cycles", r_de_cnt, 32'd12);
        chk("restart_last_addr", {2'd0, FB_ADDR}, 32'h0000010B);

        $display("test done: total=%0d bad=%0d", r_total, r_bad);
        $finish;
    end

endmodule
`default_nettype wire
